bus_arbiter_rr: RTL and testbench

- Round-robin bus arbiter for the 4-master shared bus.
- Drives the one-hot, active-low grant_ lines and the owner index consumed by the master-side mux.
- Tracks completed transfers through the read-data/ready return path (the slave mux m_rdy_).
- Enforces a burst limit so that one master cannot starve the others.

---
 rtl/bus_arbiter_rr.sv | 100 ++++++++++
 tb/tb_bus_arbiter_rr.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the 4-master shared bus.
// Grants are one-hot and active-low. The bus parks on the last owner.
// A burst limit, counted in completed transfers, stops one master from
// holding the bus while others wait.
//
// rule    | meaning
// --------+---------------------------------------------------------------
// release | owner not requesting: hand over to the next requester in order
//         | owner+1, owner+2, owner+3; if nobody requests, stay parked
// preempt | transfer done, burst full, another requester waiting: hand over
// count   | transfer done while the owner requests: count it, saturating
// hold    | nothing changes
module bus_arbiter_rr #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m_rdy_,
  output logic       m0_grant_,
  output logic       m1_grant_,
  output logic       m2_grant_,
  output logic       m3_grant_,
  output logic [1:0] owner,
  output logic       preempt
);

  // Last count before a burst is full. With MAX_BURST of 0 the counter never moves.
  localparam logic [CNT_W-1:0] LAST = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);

  logic [3:0]       req;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;
  logic             found;
  logic [1:0]       next_req;
  logic [1:0]       cand;

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Find the first requester other than the owner, starting at owner+1.
  // Decide on release, preemption or counting. The grant vector is computed
  // from the next owner, so grants switch on the same edge as owner.
  always_comb begin
    found     = 1'b0;
    next_req  = owner_q;
    cand      = '0;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cand = owner_q + 2'(i);
      if (!found && req[cand]) begin
        found    = 1'b1;
        next_req = cand;
      end
    end
    if (!req[owner_q]) begin
      if (found) owner_d = next_req;
      cnt_d = '0;
    end else if (!m_rdy_) begin
      if (MAX_BURST != 0 && cnt_q == LAST && found) begin
        owner_d   = next_req;
        cnt_d     = '0;
        preempt_d = 1'b1;
      end else if (MAX_BURST != 0 && cnt_q != LAST) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    grant_d = ~(4'b0001 << owner_d);
  end

  // Arbitration state register with synchronous reset. After reset the bus is parked on master 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= 2'd0;
      grant_q   <= 4'b1110;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign owner     = owner_q;
  assign preempt   = preempt_q;
  assign m0_grant_ = grant_q[0];
  assign m1_grant_ = grant_q[1];
  assign m2_grant_ = grant_q[2];
  assign m3_grant_ = grant_q[3];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr. It runs directed scenarios and then random
// traffic against a reference model held as plain integers.
module tb_bus_arbiter_rr;

  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       rdy_n;
  logic       m0_grant_, m1_grant_, m2_grant_, m3_grant_;
  logic [1:0] owner;
  logic       preempt;
  logic [3:0] grants;

  int n_checks = 0;
  int n_fail   = 0;

  int m_owner = 0;
  int m_cnt   = 0;
  bit m_pre   = 1'b0;

  always #5 clk = ~clk;

  assign grants = {m3_grant_, m2_grant_, m1_grant_, m0_grant_};

  bus_arbiter_rr #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (req_n[0]),
    .m1_req_  (req_n[1]),
    .m2_req_  (req_n[2]),
    .m3_req_  (req_n[3]),
    .m_rdy_   (rdy_n),
    .m0_grant_(m0_grant_),
    .m1_grant_(m1_grant_),
    .m2_grant_(m2_grant_),
    .m3_grant_(m3_grant_),
    .owner    (owner),
    .preempt  (preempt)
  );

  // Reference model. It applies the arbitration rules with modulo arithmetic
  // to the inputs present at the coming edge, then advances one clock.
  task automatic tick();
    int  n_owner, n_cnt, other;
    bit  n_pre;
    n_owner = m_owner;
    n_cnt   = m_cnt;
    n_pre   = 1'b0;
    other   = -1;
    for (int k = 1; k <= 3; k++)
      if (other < 0 && req_n[(m_owner + k) % 4] == 1'b0) other = (m_owner + k) % 4;
    if (reset) begin
      n_owner = 0;
      n_cnt   = 0;
    end else if (req_n[m_owner] == 1'b1) begin
      if (other >= 0) n_owner = other;
      n_cnt = 0;
    end else if (rdy_n == 1'b0) begin
      if (MAXB != 0 && m_cnt == MAXB - 1 && other >= 0) begin
        n_owner = other;
        n_cnt   = 0;
        n_pre   = 1'b1;
      end else if (MAXB != 0 && m_cnt < MAXB - 1) begin
        n_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    m_owner = n_owner;
    m_cnt   = n_cnt;
    m_pre   = n_pre;
  endtask

  task automatic test_reset();
    logic [3:0] exp_g;
    reset = 1'b1;
    req_n = 4'b0000;
    rdy_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_g = 4'b1110;
      n_checks++;
      if (owner !== 2'd0 || grants !== exp_g || preempt !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: owner=%0d grants=%b preempt=%b required owner=0 grants=%b preempt=0",
                 owner, grants, preempt, exp_g);
      end
    end
    reset = 1'b0;
    rdy_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_o [4] = '{1, 2, 3, 0};
    req_n = 4'b0000;
    tick();
    for (int r = 0; r < 4; r++) begin
      req_n = 4'b0000;
      req_n[r] = 1'b1;
      tick();
      n_checks++;
      if (owner !== 2'(exp_o[r]) || owner !== 2'(m_owner) || grants !== (4'b1111 ^ (4'b0001 << m_owner))) begin
        n_fail++;
        $display("FAIL round_robin step %0d: owner=%0d grants=%b required owner=%0d", r, owner, grants, exp_o[r]);
      end
    end
  endtask

  task automatic test_parking();
    req_n = 4'b1011;
    tick();
    req_n = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (owner !== 2'd2 || m2_grant_ !== 1'b0 || grants !== 4'b1011) begin
        n_fail++;
        $display("FAIL parking cycle %0d: owner=%0d grants=%b required owner=2 grants=1011", c, owner, grants);
      end
    end
    req_n = 4'b1101;
    tick();
    n_checks++;
    if (owner !== 2'd1 || grants !== 4'b1101) begin
      n_fail++;
      $display("FAIL parking_wake: owner=%0d grants=%b required owner=1 grants=1101", owner, grants);
    end
  endtask

  task automatic test_burst_preempt();
    logic [1:0] exp_o;
    req_n = 4'b1101;
    rdy_n = 1'b1;
    tick();
    req_n = 4'b0101;
    for (int p = 1; p <= 8; p++) begin
      rdy_n = 1'b1;
      tick();
      rdy_n = 1'b0;
      tick();
      rdy_n = 1'b1;
      exp_o = (p == 8) ? 2'd3 : 2'd1;
      n_checks++;
      if (owner !== exp_o || owner !== 2'(m_owner) || preempt !== (p == 8) || preempt !== m_pre) begin
        n_fail++;
        $display("FAIL burst pulse %0d: owner=%0d preempt=%b required owner=%0d preempt=%b",
                 p, owner, preempt, exp_o, (p == 8));
      end
    end
    tick();
    n_checks++;
    if (preempt !== 1'b0 || owner !== 2'd3) begin
      n_fail++;
      $display("FAIL burst_pulse_width: owner=%0d preempt=%b required owner=3 preempt=0", owner, preempt);
    end
  endtask

  task automatic test_no_preempt();
    req_n = 4'b1101;
    tick();
    for (int p = 0; p < 20; p++) begin
      rdy_n = 1'b0;
      tick();
      rdy_n = 1'b1;
      n_checks++;
      if (owner !== 2'd1 || preempt !== 1'b0) begin
        n_fail++;
        $display("FAIL sole_requester pulse %0d: owner=%0d preempt=%b required owner=1 preempt=0", p, owner, preempt);
      end
    end
    req_n = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (owner !== 2'd1 || preempt !== 1'b0) begin
        n_fail++;
        $display("FAIL competitor_wait %0d: owner=%0d preempt=%b required owner=1 preempt=0", c, owner, preempt);
      end
    end
    rdy_n = 1'b0;
    tick();
    rdy_n = 1'b1;
    n_checks++;
    if (owner !== 2'd3 || preempt !== 1'b1 || grants !== 4'b0111) begin
      n_fail++;
      $display("FAIL competitor_handover: owner=%0d preempt=%b grants=%b required owner=3 preempt=1 grants=0111",
               owner, preempt, grants);
    end
  endtask

  task automatic test_reset_midburst();
    req_n = 4'b1011;
    rdy_n = 1'b1;
    tick();
    for (int p = 0; p < 5; p++) begin
      rdy_n = 1'b0;
      tick();
    end
    reset = 1'b1;
    req_n = 4'b0000;
    rdy_n = 1'b0;
    tick();
    reset = 1'b0;
    rdy_n = 1'b1;
    n_checks++;
    if (owner !== 2'd0 || grants !== 4'b1110 || preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midburst: owner=%0d grants=%b required owner=0 grants=1110", owner, grants);
    end
    req_n = 4'b1010;
    for (int p = 1; p <= 8; p++) begin
      rdy_n = 1'b0;
      tick();
      rdy_n = 1'b1;
      n_checks++;
      if (owner !== ((p == 8) ? 2'd2 : 2'd0) || preempt !== (p == 8)) begin
        n_fail++;
        $display("FAIL after_reset pulse %0d: owner=%0d preempt=%b required owner=%0d preempt=%b",
                 p, owner, preempt, (p == 8) ? 2 : 0, (p == 8));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      req_n = 4'($urandom_range(0, 15));
      rdy_n = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      reset = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (owner !== 2'(m_owner) || grants !== (4'b1111 ^ (4'b0001 << m_owner)) || preempt !== m_pre) begin
        n_fail++;
        $display("FAIL random cycle %0d: owner=%0d grants=%b preempt=%b required owner=%0d grants=%b preempt=%b",
                 c, owner, grants, preempt, m_owner, 4'b1111 ^ (4'b0001 << m_owner), m_pre);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_n = 4'b1111;
    rdy_n = 1'b1;
    test_reset();
    test_round_robin();
    test_parking();
    test_burst_preempt();
    test_no_preempt();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
